// File: rtl/systolic_array_acc.sv
// Rank-1-update systolic matrix multiplier with per-PE accumulators.
// One operand port loads an A column (H values) then a B row (W values);
// a skewed H x W grid accumulates a[r]*b[c] into PE(r,c). A flush drains
// C row-major over a valid/yumi port and auto-clears the accumulators.
module systolic_array_acc #(
    parameter int width_p        = 8,
    parameter int acc_width_p    = 16,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int signed_p       = 0,
    parameter int saturate_p     = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     data_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   yumi_i,
    output logic [acc_width_p-1:0] data_o,
    output logic                   last_o,
    output logic                   busy_o
);

    localparam int H  = array_height_p;
    localparam int W  = array_width_p;
    localparam int N  = H * W;
    localparam int AW = acc_width_p;
    localparam int PW = 2 * width_p;
    // Internal arithmetic width: wide enough for the full product or the
    // accumulator, plus headroom for the sum and a sign bit.
    localparam int XW = ((PW > AW) ? PW : AW) + 2;
    localparam int CW = $clog2(H + W);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [XW-1:0] LP_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] LP_MAX = (signed_p != 0) ?
        ((LP_ONE <<< (AW - 1)) - LP_ONE) : ((LP_ONE << AW) - LP_ONE);
    localparam logic signed [XW-1:0] LP_MIN = (signed_p != 0) ?
        (-(LP_ONE <<< (AW - 1))) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_ld;
    logic [CW-1:0]      r_t;
    logic [KW-1:0]      r_k;
    logic [width_p-1:0] r_abuf [H];
    logic [width_p-1:0] r_bbuf [W];
    logic [width_p-1:0] r_ah   [H][W];
    logic [width_p-1:0] r_bv   [H][W];
    logic [AW-1:0]      r_acc  [N];

    logic [width_p-1:0] w_a [H][W];
    logic [width_p-1:0] w_b [H][W];
    logic               w_last;
    logic               w_step;
    logic               w_clr;
    logic [AW-1:0]      w_data;

    // Extend an accumulator-width value into the internal arithmetic width.
    function automatic logic signed [XW-1:0] f_ext(input logic [AW-1:0] v);
        if (signed_p != 0)
            return {{(XW-AW){v[AW-1]}}, v};
        else
            return {{(XW-AW){1'b0}}, v};
    endfunction

    // One multiply-accumulate step: product limited to the accumulator
    // range (clamp or truncate), then the sum clamped or wrapped.
    function automatic logic [AW-1:0] f_mac(input logic [AW-1:0]      acc,
                                           input logic [width_p-1:0] a,
                                           input logic [width_p-1:0] b);
        logic [PW-1:0]          v_ax;
        logic [PW-1:0]          v_bx;
        logic [PW-1:0]          v_p;
        logic signed [XW-1:0]   v_pe;
        logic signed [XW-1:0]   v_s;
        if (signed_p != 0) begin
            v_ax = {{width_p{a[width_p-1]}}, a};
            v_bx = {{width_p{b[width_p-1]}}, b};
        end else begin
            v_ax = {{width_p{1'b0}}, a};
            v_bx = {{width_p{1'b0}}, b};
        end
        v_p = v_ax * v_bx;
        if (signed_p != 0)
            v_pe = {{(XW-PW){v_p[PW-1]}}, v_p};
        else
            v_pe = {{(XW-PW){1'b0}}, v_p};
        if (saturate_p != 0) begin
            if (v_pe > LP_MAX)
                v_pe = LP_MAX;
            else if (v_pe < LP_MIN)
                v_pe = LP_MIN;
        end else begin
            v_pe = f_ext(v_pe[AW-1:0]);
        end
        v_s = f_ext(acc) + v_pe;
        if (saturate_p != 0) begin
            if (v_s > LP_MAX)
                v_s = LP_MAX;
            else if (v_s < LP_MIN)
                v_s = LP_MIN;
        end
        return v_s[AW-1:0];
    endfunction

    assign w_last  = (r_state == S_DRAIN) && (r_k == KW'(N - 1));
    assign w_step  = en_i && (r_state == S_COMPUTE);
    // Accumulators clear on an uncontested clear in IDLE or on the final yumi.
    assign w_clr   = en_i && (((r_state == S_IDLE) && !valid_i && !flush_i && clear_i) ||
                              (w_last && yumi_i));

    assign ready_o = reset_n_i && en_i && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign valid_o = (r_state == S_DRAIN);
    assign last_o  = w_last;
    assign busy_o  = (r_state != S_IDLE);
    assign data_o  = w_data;

    // Skewed injection: a[r] enters row r in cycle r, b[c] enters column c
    // in cycle c, so both reach PE(r,c) in cycle r+c.
    for (genvar gr = 0; gr < H; gr++) begin : g_row
        for (genvar gc = 0; gc < W; gc++) begin : g_col
            if (gc == 0) begin : g_a_edge
                assign w_a[gr][gc] = (r_t == CW'(gr)) ? r_abuf[gr] : '0;
            end else begin : g_a_pipe
                assign w_a[gr][gc] = r_ah[gr][gc-1];
            end
            if (gr == 0) begin : g_b_edge
                assign w_b[gr][gc] = (r_t == CW'(gc)) ? r_bbuf[gc] : '0;
            end else begin : g_b_pipe
                assign w_b[gr][gc] = r_bv[gr-1][gc];
            end
        end
    end

    // Control FSM: operand load sequencing, compute timing, drain index.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_ld    <= '0;
            r_t     <= '0;
            r_k     <= '0;
            for (int unsigned i = 0; i < H; i++) r_abuf[i] <= '0;
            for (int unsigned j = 0; j < W; j++) r_bbuf[j] <= '0;
        end else if (en_i) begin
            unique case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_abuf[0] <= data_i;
                        r_ld      <= CW'(1);
                        r_state   <= S_LOAD;
                    end else if (flush_i) begin
                        r_k     <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_LOAD: begin
                    if (valid_i) begin
                        for (int unsigned i = 0; i < H; i++)
                            if (r_ld == CW'(i)) r_abuf[i] <= data_i;
                        for (int unsigned j = 0; j < W; j++)
                            if (r_ld == CW'(H + j)) r_bbuf[j] <= data_i;
                        if (r_ld == CW'(H + W - 1)) begin
                            r_ld    <= '0;
                            r_t     <= '0;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_ld <= r_ld + CW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_t == CW'(H + W - 2)) begin
                        r_t     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_t <= r_t + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (yumi_i) begin
                        if (w_last) begin
                            r_k     <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand pipelines: a moves right, b moves down, one PE per compute cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned r = 0; r < H; r++)
                for (int unsigned c = 0; c < W; c++) begin
                    r_ah[r][c] <= '0;
                    r_bv[r][c] <= '0;
                end
        end else if (w_step) begin
            for (int unsigned r = 0; r < H; r++)
                for (int unsigned c = 0; c < W; c++) begin
                    r_ah[r][c] <= w_a[r][c];
                    r_bv[r][c] <= w_b[r][c];
                end
        end
    end

    // Per-PE accumulators: PE(r,c) updates only in compute cycle r+c.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < N; i++) r_acc[i] <= '0;
        end else if (w_clr) begin
            for (int unsigned i = 0; i < N; i++) r_acc[i] <= '0;
        end else if (w_step) begin
            for (int unsigned r = 0; r < H; r++)
                for (int unsigned c = 0; c < W; c++)
                    if (r_t == CW'(r + c))
                        r_acc[r*W + c] <= f_mac(r_acc[r*W + c], w_a[r][c], w_b[r][c]);
        end
    end

    // Result mux: drain element k is accumulator k (row-major); zero elsewhere.
    always_comb begin
        w_data = '0;
        if (r_state == S_DRAIN)
            for (int unsigned i = 0; i < N; i++)
                if (r_k == KW'(i)) w_data = r_acc[i];
    end

endmodule

// File: tb/tb_systolic_array_acc.sv
// Randomised bench for systolic_array_acc: two instances (unsigned wrap,
// signed saturating with a narrow accumulator) share one H=2 x W=3 stimulus
// stream and are checked against an integer reference model.
module tb_systolic_array_acc;

    localparam int H   = 2;
    localparam int W   = 3;
    localparam int N   = H * W;
    localparam int AW0 = 16;
    localparam int AW1 = 12;

    logic           clk = 1'b0;
    logic           rst_n, en, clear, valid, flush, yumi;
    logic [7:0]     din;
    logic           rdy0, vo0, last0, busy0;
    logic [AW0-1:0] dout0;
    logic           rdy1, vo1, last1, busy1;
    logic [AW1-1:0] dout1;

    int     n_total = 0;
    int     n_bad   = 0;
    longint m0 [N];
    longint m1 [N];
    logic [7:0] pa [H];
    logic [7:0] pb [W];

    always #5 clk = ~clk;

    systolic_array_acc #(
        .width_p(8), .acc_width_p(AW0), .array_width_p(W), .array_height_p(H),
        .signed_p(0), .saturate_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clear),
        .valid_i(valid), .ready_o(rdy0), .data_i(din), .flush_i(flush),
        .valid_o(vo0), .yumi_i(yumi), .data_o(dout0), .last_o(last0), .busy_o(busy0)
    );

    systolic_array_acc #(
        .width_p(8), .acc_width_p(AW1), .array_width_p(W), .array_height_p(H),
        .signed_p(1), .saturate_p(1)
    ) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clear),
        .valid_i(valid), .ready_o(rdy1), .data_i(din), .flush_i(flush),
        .valid_o(vo1), .yumi_i(yumi), .data_o(dout1), .last_o(last1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrapv(input longint v, input bit sgn, input int aw);
        longint m = longint'(1) << aw;
        longint r = v & (m - 1);
        if (sgn && r >= (m >> 1)) r -= m;
        return r;
    endfunction

    function automatic longint clampv(input longint v, input bit sgn, input int aw);
        longint mx = sgn ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
        longint mn = sgn ? -(longint'(1) << (aw - 1)) : 0;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint mac(input longint acc, input logic [7:0] a, input logic [7:0] b,
                                   input bit sgn, input bit sat, input int aw);
        longint av = sgn ? longint'($signed(a)) : longint'(a);
        longint bv = sgn ? longint'($signed(b)) : longint'(b);
        longint p  = av * bv;
        longint s;
        p = sat ? clampv(p, sgn, aw) : wrapv(p, sgn, aw);
        s = acc + p;
        return sat ? clampv(s, sgn, aw) : wrapv(s, sgn, aw);
    endfunction

    function automatic logic [31:0] bits(input longint v, input int aw);
        return 32'(v & ((longint'(1) << aw) - 1));
    endfunction

    task automatic model_zero();
        for (int i = 0; i < N; i++) begin
            m0[i] = 0;
            m1[i] = 0;
        end
    endtask

    // Stream pa then pb; optional gaps, stray flush/clear, and a 5-cycle stall.
    task automatic load_pass(input bit gaps, input bit noise, input bit stall);
        logic [7:0] seq [H+W];
        int n;
        for (int i = 0; i < H; i++) seq[i] = pa[i];
        for (int j = 0; j < W; j++) seq[H+j] = pb[j];
        for (int i = 0; i < H + W; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            chk("ready_load0", rdy0, 1);
            chk("ready_load1", rdy1, 1);
            valid = 1'b1;
            din   = seq[i];
            if (noise) begin
                flush = 1'($urandom_range(0, 1));
                clear = 1'($urandom_range(0, 1));
            end
            tick();
            valid = 1'b0;
            flush = 1'b0;
            clear = 1'b0;
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                m0[r*W+c] = mac(m0[r*W+c], pa[r], pb[c], 1'b0, 1'b0, AW0);
                m1[r*W+c] = mac(m1[r*W+c], pa[r], pb[c], 1'b1, 1'b1, AW1);
            end
        chk("busy_compute", busy0, 1);
        chk("ready_compute", rdy0, 0);
        n = 0;
        while (rdy0 !== 1'b1 && n < 40) begin
            if (stall && n == 1) en = 1'b0;
            if (stall && n == 6) en = 1'b1;
            tick();
            n++;
        end
        en = 1'b1;
        chk("ready_delay", n, stall ? 9 : 4);
        chk("ready1_after", rdy1, 1);
        chk("busy_idle", busy0, 0);
    endtask

    // Flush and consume all N results; rnd adds held cycles (some with en=0).
    task automatic drain(input bit rnd);
        logic [31:0] e0, e1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < N; k++) begin
            e0 = bits(m0[k], AW0);
            e1 = bits(m1[k], AW1);
            chk("valid0", vo0, 1);
            chk("valid1", vo1, 1);
            chk("ready_drain", rdy0, 0);
            chk("data0", dout0, e0);
            chk("data1", dout1, e1);
            chk("last0", last0, k == N - 1);
            chk("last1", last1, k == N - 1);
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    en   = 1'($urandom_range(0, 1));
                    yumi = ~en & 1'($urandom_range(0, 1));
                    tick();
                    en   = 1'b1;
                    yumi = 1'b0;
                    chk("hold_valid", vo0, 1);
                    chk("hold0", dout0, e0);
                    chk("hold1", dout1, e1);
                end
            end
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
        end
        chk("drain_busy", busy0, 0);
        chk("drain_valid", vo0, 0);
        chk("drain_data0", dout0, 0);
        chk("drain_last", last0, 0);
        model_zero();
    endtask

    task automatic set_pass(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        pa[0] = a0; pa[1] = a1;
        pb[0] = b0; pb[1] = b1; pb[2] = b2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clear = 1'b0; valid = 1'b0;
        flush = 1'b0; yumi = 1'b0; din = '0;
        model_zero();
        #1;
        chk("rst_ready", rdy0, 0);
        chk("rst_valid", vo0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_data", dout0, 0);
        chk("rst_last", last1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("idle_ready", rdy0, 1);

        // Directed pass, back-to-back drain, then an immediate empty drain.
        set_pass(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        load_pass(1'b0, 1'b0, 1'b0);
        drain(1'b0);
        drain(1'b0);

        // Same pass with a 5-cycle enable stall during compute.
        load_pass(1'b0, 1'b0, 1'b1);
        drain(1'b1);

        // Explicit clear in IDLE discards a completed pass.
        set_pass(8'd7, 8'd9, 8'd11, 8'd13, 8'd200);
        load_pass(1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        drain(1'b0);

        // Randomised multi-pass accumulation.
        repeat (20) begin
            repeat ($urandom_range(1, 3)) begin
                set_pass(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                load_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
            drain(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a drain.
        set_pass(8'd50, 8'd60, 8'd70, 8'd80, 8'd90);
        load_pass(1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", vo0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_ready", rdy0, 0);
        chk("mid_rst_data", dout0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_zero();
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
